// File: rtl/shiftreg_frame_gen.sv
// Serial frame generator: a static word followed by a serially loaded dynamic word on one line.
// Optional even-parity trailer bit when SHIFTREG_FRAME_PARITY_EN is defined.
module shiftreg_frame_gen #(
   parameter int                    SIZESRSTAT = 88,
   parameter int                    SIZESRDYN  = 16,
   parameter logic [SIZESRSTAT-1:0] STAT_INIT  = 88'hABCDEF123456789ABCDEF1,
   parameter int                    BIT_DIV    = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic START,
   input  logic LOAD_VALID,
   input  logic LOAD_DIN,
   output logic SELSTAT,
   output logic SELDYN,
   output logic BUSY,
   output logic ENFIN,
   output logic generated_signal
);

   localparam int MAXSZ = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
   localparam int BIT_W = (MAXSZ > 1) ? $clog2(MAXSZ) : 1;
   localparam int DIV_W = $clog2(BIT_DIV) + 1;

   localparam logic [BIT_W-1:0] STAT_LAST = BIT_W'(SIZESRSTAT - 1);
   localparam logic [BIT_W-1:0] DYN_LAST  = BIT_W'(SIZESRDYN - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);

`ifdef SHIFTREG_FRAME_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_STAT, S_DYN, S_PAR, S_FIN} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_STAT, S_DYN, S_FIN} state_t;
`endif

   state_t                state_q, state_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [SIZESRSTAT-1:0] stat_sh_q, stat_sh_d;
   logic [SIZESRDYN-1:0]  dyn_sh_q, dyn_sh_d;
   logic [SIZESRDYN-1:0]  shadow_q, shadow_d;
`ifdef SHIFTREG_FRAME_PARITY_EN
   logic                  par_q, par_d;
`endif

   logic sel_stat_q, sel_stat_d;
   logic sel_dyn_q, sel_dyn_d;
   logic busy_q, busy_d;
   logic enfin_q, enfin_d;
   logic gen_q, gen_d;

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      div_d     = div_q;
      stat_sh_d = stat_sh_q;
      dyn_sh_d  = dyn_sh_q;
      shadow_d  = shadow_q;
`ifdef SHIFTREG_FRAME_PARITY_EN
      par_d     = par_q;
`endif

      if (LOAD_VALID) begin
         shadow_d = (shadow_q << 1) | SIZESRDYN'(LOAD_DIN);
      end

      // Current bit is always the MSB of its shift register; the word shifts once per bit period.
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d   = S_STAT;
               bit_d     = STAT_LAST;
               div_d     = DIV_LAST;
               stat_sh_d = STAT_INIT;
               dyn_sh_d  = shadow_d;
`ifdef SHIFTREG_FRAME_PARITY_EN
               par_d     = (^STAT_INIT) ^ (^shadow_d);
`endif
            end
         end
         S_STAT: begin
            if (div_q == '0) begin
               div_d = DIV_LAST;
               if (bit_q == '0) begin
                  state_d = S_DYN;
                  bit_d   = DYN_LAST;
               end else begin
                  bit_d     = bit_q - 1'b1;
                  stat_sh_d = stat_sh_q << 1;
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         S_DYN: begin
            if (div_q == '0) begin
               div_d = DIV_LAST;
               if (bit_q == '0) begin
`ifdef SHIFTREG_FRAME_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_FIN;
`endif
               end else begin
                  bit_d    = bit_q - 1'b1;
                  dyn_sh_d = dyn_sh_q << 1;
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
`ifdef SHIFTREG_FRAME_PARITY_EN
         S_PAR: begin
            if (div_q == '0) begin
               state_d = S_FIN;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they change only on clock edges.
   always_comb begin
      sel_stat_d = 1'b0;
      sel_dyn_d  = 1'b0;
      busy_d     = (state_d != S_IDLE);
      enfin_d    = (state_d == S_FIN);
      gen_d      = 1'b0;
      case (state_d)
         S_STAT: begin
            sel_stat_d = 1'b1;
            gen_d      = stat_sh_d[SIZESRSTAT-1];
         end
         S_DYN: begin
            sel_dyn_d = 1'b1;
            gen_d     = dyn_sh_d[SIZESRDYN-1];
         end
`ifdef SHIFTREG_FRAME_PARITY_EN
         S_PAR: begin
            sel_dyn_d = 1'b1;
            gen_d     = par_d;
         end
`endif
         default: begin
            gen_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         bit_q      <= '0;
         div_q      <= '0;
         stat_sh_q  <= STAT_INIT;
         dyn_sh_q   <= '0;
         shadow_q   <= '0;
`ifdef SHIFTREG_FRAME_PARITY_EN
         par_q      <= 1'b0;
`endif
         sel_stat_q <= 1'b0;
         sel_dyn_q  <= 1'b0;
         busy_q     <= 1'b0;
         enfin_q    <= 1'b0;
         gen_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         div_q      <= div_d;
         stat_sh_q  <= stat_sh_d;
         dyn_sh_q   <= dyn_sh_d;
         shadow_q   <= shadow_d;
`ifdef SHIFTREG_FRAME_PARITY_EN
         par_q      <= par_d;
`endif
         sel_stat_q <= sel_stat_d;
         sel_dyn_q  <= sel_dyn_d;
         busy_q     <= busy_d;
         enfin_q    <= enfin_d;
         gen_q      <= gen_d;
      end
   end

   assign SELSTAT          = sel_stat_q;
   assign SELDYN           = sel_dyn_q;
   assign BUSY             = busy_q;
   assign ENFIN            = enfin_q;
   assign generated_signal = gen_q;

endmodule
